sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arb_pkg.sv | 22 ++
 rtl/sram_rr_arb.sv | 19 +
 rtl/sram_arbiter.sv | 145 ++++++++++++++
 tb/tb_sram_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-port asynchronous SRAM arbiter.
package sram_arb_pkg;

    localparam int unsigned CHIP_SEL_W = 2;
    localparam int unsigned SRAM_A_W   = 20;
    localparam int unsigned DATA_W     = 8;
    localparam int unsigned NUM_CHIPS  = 4;

    // Access sequencer states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Chip number to active-low one-hot chip select
    function automatic logic [NUM_CHIPS-1:0] cs_decode(input logic [CHIP_SEL_W-1:0] chip);
        cs_decode = ~(NUM_CHIPS'(1) << chip);
    endfunction

endpackage

// File: rtl/sram_rr_arb.sv
// Two-requester round-robin grant; on a tie the port not granted last wins.
module sram_rr_arb (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // last=1 means port 1 was served most recently, so port 0 wins a tie
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates two requesters onto up to four asynchronous SRAM chips.
// Each access runs IDLE -> SETUP -> STROBE x STROBE_CYCLES -> HOLD with every
// pad-side signal registered, so strobes never glitch.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned STROBE_CYCLES = 2,   // 1..15
    parameter int unsigned ADDR_W        = 22
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_W-1:0]     p0_addr,
    input  logic [DATA_W-1:0]     p0_wdata,
    output logic                  p0_ack,
    output logic [DATA_W-1:0]     p0_rdata,

    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_W-1:0]     p1_addr,
    input  logic [DATA_W-1:0]     p1_wdata,
    output logic                  p1_ack,
    output logic [DATA_W-1:0]     p1_rdata,

    output logic [SRAM_A_W-1:0]   sram_a,
    output logic [NUM_CHIPS-1:0]  sram_cs_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [DATA_W-1:0]     sram_d_out,
    output logic                  sram_d_oe,
    input  logic [DATA_W-1:0]     sram_d_in
);

    localparam int unsigned      CNT_W    = 4;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STROBE_CYCLES - 1);

    state_t             r_state;
    logic               r_last;     // 1: port 1 was granted most recently
    logic               r_port;     // port owning the access in flight
    logic               r_we;       // latched direction of the access in flight
    logic [CNT_W-1:0]   r_cnt;      // strobe cycles already spent

    logic [1:0]         w_req;
    logic [1:0]         w_grant;
    logic               w_sel1;
    logic               w_we;
    logic [ADDR_W-1:0]  w_addr;
    logic [DATA_W-1:0]  w_wdata;

    assign w_req = {p1_req, p0_req};

    sram_rr_arb u_rr_arb (
        .req   (w_req),
        .last  (r_last),
        .grant (w_grant)
    );

    // Request fields of whichever port the arbiter picks this cycle
    assign w_sel1  = w_grant[1];
    assign w_we    = w_sel1 ? p1_we    : p0_we;
    assign w_addr  = w_sel1 ? p1_addr  : p0_addr;
    assign w_wdata = w_sel1 ? p1_wdata : p0_wdata;

    // Access sequencer with registered SRAM strobes, acks and read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_last     <= 1'b1;
            r_port     <= 1'b0;
            r_we       <= 1'b0;
            r_cnt      <= '0;
            sram_a     <= '0;
            sram_cs_n  <= '1;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_d_oe  <= 1'b0;
            sram_d_out <= '0;
            p0_ack     <= 1'b0;
            p1_ack     <= 1'b0;
            p0_rdata   <= '0;
            p1_rdata   <= '0;
        end else begin
            p0_ack <= 1'b0;
            p1_ack <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Latch the whole request so later port changes cannot leak in
                    if (|w_grant) begin
                        r_state   <= ST_SETUP;
                        r_port    <= w_sel1;
                        r_last    <= w_sel1;
                        r_we      <= w_we;
                        sram_a    <= w_addr[SRAM_A_W-1:0];
                        sram_cs_n <= cs_decode(w_addr[SRAM_A_W +: CHIP_SEL_W]);
                        sram_d_oe <= w_we;
                        if (w_we) begin
                            sram_d_out <= w_wdata;
                        end
                    end
                end
                ST_SETUP: begin
                    r_state <= ST_STROBE;
                    r_cnt   <= '0;
                    if (r_we) begin
                        sram_we_n <= 1'b0;
                    end else begin
                        sram_oe_n <= 1'b0;
                    end
                end
                ST_STROBE: begin
                    if (r_cnt == CNT_LAST) begin
                        // Closing edge: release strobes, capture read data, ack in HOLD
                        r_state   <= ST_HOLD;
                        sram_oe_n <= 1'b1;
                        sram_we_n <= 1'b1;
                        if (r_port) begin
                            p1_ack <= 1'b1;
                        end else begin
                            p0_ack <= 1'b1;
                        end
                        if (!r_we) begin
                            if (r_port) begin
                                p1_rdata <= sram_d_in;
                            end else begin
                                p0_rdata <= sram_d_in;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_HOLD: begin
                    // Address stays put; chips deselect for the turnaround cycle
                    r_state   <= ST_IDLE;
                    sram_cs_n <= '1;
                    sram_d_oe <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM behavioural model, scoreboard of expected acks,
// a vector table of single accesses and hand-written multi-cycle sequences.
module tb_sram_arbiter;

    localparam int unsigned SC = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [21:0] p0_addr, p1_addr;
    logic [7:0]  p0_wdata, p1_wdata, p0_rdata, p1_rdata;
    logic        p0_ack, p1_ack;
    logic [19:0] sram_a;
    logic [3:0]  sram_cs_n;
    logic        sram_oe_n, sram_we_n, sram_d_oe;
    logic [7:0]  sram_d_out, sram_d_in;

    logic        b_p0_req, b_p0_we, b_p1_req, b_p1_we;
    logic [21:0] b_p0_addr, b_p1_addr;
    logic [7:0]  b_p0_wdata, b_p1_wdata, b_p0_rdata, b_p1_rdata;
    logic        b_p0_ack, b_p1_ack;
    logic [19:0] b_sram_a;
    logic [3:0]  b_sram_cs_n;
    logic        b_sram_oe_n, b_sram_we_n, b_sram_d_oe;
    logic [7:0]  b_sram_d_out, b_sram_d_in;

    sram_arbiter #(.STROBE_CYCLES(SC), .ADDR_W(22)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .sram_a(sram_a), .sram_cs_n(sram_cs_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .sram_d_out(sram_d_out), .sram_d_oe(sram_d_oe), .sram_d_in(sram_d_in)
    );

    sram_arbiter #(.STROBE_CYCLES(1), .ADDR_W(22)) dut_b (
        .clk(clk), .rst(rst),
        .p0_req(b_p0_req), .p0_we(b_p0_we), .p0_addr(b_p0_addr), .p0_wdata(b_p0_wdata),
        .p0_ack(b_p0_ack), .p0_rdata(b_p0_rdata),
        .p1_req(b_p1_req), .p1_we(b_p1_we), .p1_addr(b_p1_addr), .p1_wdata(b_p1_wdata),
        .p1_ack(b_p1_ack), .p1_rdata(b_p1_rdata),
        .sram_a(b_sram_a), .sram_cs_n(b_sram_cs_n), .sram_oe_n(b_sram_oe_n), .sram_we_n(b_sram_we_n),
        .sram_d_out(b_sram_d_out), .sram_d_oe(b_sram_d_oe), .sram_d_in(b_sram_d_in)
    );

    typedef struct {
        bit          port;
        bit          we;
        logic [21:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rdata;
        logic [3:0]  cs;
    } vec_t;

    typedef struct {
        bit          port;
        bit          we;
        logic [19:0] a;
        logic [7:0]  rdata;
        logic [3:0]  cs;
        int          cyc;
    } exp_t;

    localparam int NV = 9;
    vec_t vt [NV];
    exp_t sb [$];
    logic [7:0] mem [logic [21:0]];

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int n_we = 0, n_oe = 0, n_doe = 0;
    int rem0 = 0, rem1 = 0;
    int k;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic int chip_of(input logic [3:0] cs);
        case (cs)
            4'b1110: return 0;
            4'b1101: return 1;
            4'b1011: return 2;
            4'b0111: return 3;
            default: return -1;
        endcase
    endfunction

    function automatic logic [7:0] rd_mem(input logic [21:0] key);
        if (mem.exists(key)) return mem[key];
        return 8'h00;
    endfunction

    // One clock: SRAM model, strobe counters, scoreboard on acks, requester release
    task automatic step();
        int          ch;
        logic [21:0] key;
        exp_t        e;
        @(posedge clk);
        #1;
        cyc++;
        ch  = chip_of(sram_cs_n);
        key = {2'(ch), sram_a};
        if (!sram_we_n && ch >= 0) mem[key] = sram_d_out;
        sram_d_in = (!sram_oe_n && ch >= 0) ? rd_mem(key) : 8'h00;
        if (!sram_we_n) n_we++;
        if (!sram_oe_n) n_oe++;
        if (sram_d_oe)  n_doe++;
        chk("acks_exclusive", 32'(p0_ack && p1_ack), 32'd0);
        if (p0_ack || p1_ack) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got p0=%0b p1=%0b expected none (cycle %0d)", p0_ack, p1_ack, cyc);
            end else begin
                e = sb.pop_front();
                chk("ack_port", 32'(p1_ack), 32'(e.port));
                chk("ack_cycle", cyc, e.cyc);
                chk("cs_n", 32'(sram_cs_n), 32'(e.cs));
                chk("sram_a", 32'(sram_a), 32'(e.a));
                chk("we_low_cycles", n_we, e.we ? SC : 0);
                chk("oe_low_cycles", n_oe, e.we ? 0 : SC);
                chk("d_oe_cycles", n_doe, e.we ? SC + 2 : 0);
                if (!e.we) chk("rdata", 32'(e.port ? p1_rdata : p0_rdata), 32'(e.rdata));
            end
            n_we = 0; n_oe = 0; n_doe = 0;
            if (p0_ack) begin rem0--; if (rem0 <= 0) p0_req = 1'b0; end
            if (p1_ack) begin rem1--; if (rem1 <= 0) p1_req = 1'b0; end
        end
        if (rst) begin
            n_we = 0; n_oe = 0; n_doe = 0;
        end
    endtask

    task automatic issue(input bit port, input bit we, input logic [21:0] addr, input logic [7:0] wd);
        if (port) begin
            p1_we = we; p1_addr = addr; p1_wdata = wd; p1_req = 1'b1; rem1 = 1;
        end else begin
            p0_we = we; p0_addr = addr; p0_wdata = wd; p0_req = 1'b1; rem0 = 1;
        end
    endtask

    task automatic expect_ack(input bit port, input bit we, input logic [21:0] addr,
                              input logic [7:0] rd, input logic [3:0] cs, input int at);
        exp_t e;
        e.port = port; e.we = we; e.a = addr[19:0]; e.rdata = rd; e.cs = cs; e.cyc = at;
        sb.push_back(e);
    endtask

    // Run until every expected ack arrived, then one extra cycle back into IDLE
    task automatic drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: got %0d pending acks expected 0", sb.size());
            sb.delete();
            p0_req = 1'b0; p1_req = 1'b0;
        end
        step();
    endtask

    initial begin
        int nb_we, nacks, a1, a2;

        vt[0] = '{1'b0, 1'b1, 22'h012345, 8'hA5, 8'h00, 4'b1110};
        vt[1] = '{1'b0, 1'b0, 22'h012345, 8'h00, 8'hA5, 4'b1110};
        vt[2] = '{1'b1, 1'b1, 22'h3FFFFF, 8'h3C, 8'h00, 4'b0111};
        vt[3] = '{1'b1, 1'b0, 22'h3FFFFF, 8'h00, 8'h3C, 4'b0111};
        vt[4] = '{1'b0, 1'b1, 22'h100000, 8'h5A, 8'h00, 4'b1101};
        vt[5] = '{1'b1, 1'b0, 22'h100000, 8'h00, 8'h5A, 4'b1101};
        vt[6] = '{1'b1, 1'b1, 22'h2ABCDE, 8'h81, 8'h00, 4'b1011};
        vt[7] = '{1'b0, 1'b0, 22'h2ABCDE, 8'h00, 8'h81, 4'b1011};
        vt[8] = '{1'b0, 1'b0, 22'h112345, 8'h00, 8'h00, 4'b1101};

        rst = 1'b1;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        sram_d_in = 8'h00;
        b_p0_req = 1'b0; b_p0_we = 1'b0; b_p0_addr = '0; b_p0_wdata = '0;
        b_p1_req = 1'b0; b_p1_we = 1'b0; b_p1_addr = '0; b_p1_wdata = '0;
        b_sram_d_in = 8'h00;

        // Reset values
        step(); step();
        chk("rst_cs_n", 32'(sram_cs_n), 32'hF);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_d_oe", 32'(sram_d_oe), 32'd0);
        chk("rst_a", 32'(sram_a), 32'd0);
        chk("rst_d_out", 32'(sram_d_out), 32'd0);
        chk("rst_acks", 32'({p1_ack, p0_ack}), 32'd0);
        chk("rst_rdata", 32'({p1_rdata, p0_rdata}), 32'd0);
        rst = 1'b0;
        step();

        // Single accesses; port inputs are scrambled once the request is latched
        for (int i = 0; i < NV; i++) begin
            k = cyc;
            issue(vt[i].port, vt[i].we, vt[i].addr, vt[i].wdata);
            expect_ack(vt[i].port, vt[i].we, vt[i].addr, vt[i].rdata, vt[i].cs, k + SC + 2);
            step(); step();
            if (vt[i].port) begin
                p1_addr = ~p1_addr; p1_wdata = ~p1_wdata; p1_we = ~p1_we;
            end else begin
                p0_addr = ~p0_addr; p0_wdata = ~p0_wdata; p0_we = ~p0_we;
            end
            drain(40);
        end
        chk("mem_chip0_12345", 32'(rd_mem(22'h012345)), 32'hA5);
        chk("mem_chip3_fffff", 32'(rd_mem(22'h3FFFFF)), 32'h3C);

        // Reset in the middle of a write strobe aborts cleanly
        k = cyc;
        issue(1'b0, 1'b1, 22'h000777, 8'hEE);
        step(); step();
        chk("strobe_we_n_low", 32'(sram_we_n), 32'd0);
        rst = 1'b1; p0_req = 1'b0; rem0 = 0;
        step();
        chk("abort_we_n", 32'(sram_we_n), 32'd1);
        chk("abort_cs_n", 32'(sram_cs_n), 32'hF);
        chk("abort_ack", 32'({p1_ack, p0_ack}), 32'd0);
        rst = 1'b0;
        repeat (8) step();
        chk("abort_idle_cs_n", 32'(sram_cs_n), 32'hF);
        k = cyc;
        issue(1'b0, 1'b1, 22'h000777, 8'h3E);
        expect_ack(1'b0, 1'b1, 22'h000777, 8'h00, 4'b1110, k + SC + 2);
        drain(40);
        k = cyc;
        issue(1'b1, 1'b0, 22'h000777, 8'h00);
        expect_ack(1'b1, 1'b0, 22'h000777, 8'h3E, 4'b1110, k + SC + 2);
        drain(40);

        // Simultaneous requests straight after reset, both held: p0,p1,p0,p1
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        k = cyc;
        issue(1'b0, 1'b1, 22'h000100, 8'h11);
        issue(1'b1, 1'b1, 22'h100200, 8'h22);
        rem0 = 2; rem1 = 2;
        expect_ack(1'b0, 1'b1, 22'h000100, 8'h00, 4'b1110, k + SC + 2);
        expect_ack(1'b1, 1'b1, 22'h100200, 8'h00, 4'b1101, k + SC + 2 + (SC + 3));
        expect_ack(1'b0, 1'b1, 22'h000100, 8'h00, 4'b1110, k + SC + 2 + 2 * (SC + 3));
        expect_ack(1'b1, 1'b1, 22'h100200, 8'h00, 4'b1101, k + SC + 2 + 3 * (SC + 3));
        drain(60);
        chk("mem_tie_p0", 32'(rd_mem(22'h000100)), 32'h11);
        chk("mem_tie_p1", 32'(rd_mem(22'h100200)), 32'h22);

        // Single-cycle strobe instance: two back-to-back writes from a held request
        k = cyc;
        nb_we = 0; nacks = 0; a1 = -1; a2 = -1;
        b_p0_we = 1'b1; b_p0_addr = 22'h012345; b_p0_wdata = 8'hA5; b_p0_req = 1'b1;
        for (int j = 0; j < 20; j++) begin
            step();
            chk("b_oe_n_high", 32'(b_sram_oe_n), 32'd1);
            if (!b_sram_we_n) begin
                nb_we++;
                chk("b_cs_n", 32'(b_sram_cs_n), 32'hE);
                chk("b_a", 32'(b_sram_a), 32'h12345);
                chk("b_d_out", 32'(b_sram_d_out), 32'hA5);
                chk("b_d_oe", 32'(b_sram_d_oe), 32'd1);
            end
            if (b_p1_ack) chk("b_p1_ack", 32'(b_p1_ack), 32'd0);
            if (b_p0_ack) begin
                nacks++;
                if (nacks == 1) a1 = cyc;
                else if (nacks == 2) begin
                    a2 = cyc;
                    b_p0_req = 1'b0;
                end
            end
        end
        chk("b_we_low_total", nb_we, 32'd2);
        chk("b_ack_count", nacks, 32'd2);
        chk("b_first_ack", a1, k + 3);
        chk("b_period", a2 - a1, 32'd4);
        chk("b_rdata", 32'({b_p1_rdata, b_p0_rdata}), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
